// File: rtl/serial_sum_collector_if.sv
// ---------------------------------------------------------------------------
// serial_sum_collector_if
//   Bundles the two streams of the serial sum collector:
//     - input bit stream from a bit-serial adder:
//         sum_bit, sum_valid, frame_start, cout_bit
//     - output result stream (valid/ready handshake):
//         res_data[WIDTH-1:0], res_cout, res_valid, res_ready
//   master : producer of the bit stream and consumer of results (the environment)
//   slave  : the collector itself
// ---------------------------------------------------------------------------
interface serial_sum_collector_if #(
    parameter int WIDTH = 8
);
    logic             sum_bit;
    logic             sum_valid;
    logic             frame_start;
    logic             cout_bit;
    logic [WIDTH-1:0] res_data;
    logic             res_cout;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output sum_bit, sum_valid, frame_start, cout_bit, res_ready,
        input  res_data, res_cout, res_valid
    );

    modport slave (
        input  sum_bit, sum_valid, frame_start, cout_bit, res_ready,
        output res_data, res_cout, res_valid
    );
endinterface

// File: rtl/serial_sum_collector.sv
// ---------------------------------------------------------------------------
// serial_sum_collector
//   Deserialises the LSB-first sum bit stream of a bit-serial adder into
//   WIDTH-bit words, each paired with the adder carry-out, and buffers them
//   in a 2-entry FIFO presented on a valid/ready result port.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   reset      : asynchronous, active-high reset
//   bus        : serial_sum_collector_if.slave
//                  sum_bit/sum_valid/frame_start/cout_bit  (bit stream in)
//                  res_data/res_cout/res_valid/res_ready   (result stream out)
//   busy       : a frame is in progress (state SHIFT)
//   overrun    : sticky, a completed word was dropped because the FIFO was full
//   frame_err  : sticky, stray bit in IDLE or truncated frame detected
// ---------------------------------------------------------------------------
module serial_sum_collector #(
    parameter int WIDTH = 8   // legal range 2..16
) (
    input  logic                     clk,
    input  logic                     reset,
    serial_sum_collector_if.slave    bus,
    output logic                     busy,
    output logic                     overrun,
    output logic                     frame_err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Frame assembly state
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;

    logic             push_req;
    logic [WIDTH:0]   push_word;      // {cout, word}
    logic             frame_err_set;
    logic [WIDTH-1:0] shifted;        // shreg shifted right, sum_bit at MSB

    // -----------------------------------------------------------------------
    // Result FIFO (2 entries of {cout, word})
    // -----------------------------------------------------------------------
    logic [WIDTH:0]   mem [2];
    logic             rd_ptr, wr_ptr;
    logic [1:0]       count_q;
    logic             fifo_full;
    logic             pop;
    logic             do_push;

    // Concatenate then shift so the bit falling off the LSB drops out
    // naturally; the result equals {sum_bit, shreg_q[WIDTH-1:1]}.
    assign shifted = WIDTH'({bus.sum_bit, shreg_q} >> 1);

    // -----------------------------------------------------------------------
    // Next-state / datapath logic
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        push_req      = 1'b0;
        push_word     = {bus.cout_bit, shifted};
        frame_err_set = 1'b0;

        // With sum_valid low nothing moves: gaps between bits are unbounded.
        if (bus.sum_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.frame_start) begin
                        shreg_d = {bus.sum_bit, {(WIDTH-1){1'b0}}};
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end else begin
                        // Bit with no frame around it: drop it and flag.
                        frame_err_set = 1'b1;
                    end
                end

                SHIFT: begin
                    if (bus.frame_start) begin
                        // Truncated frame: abandon it and restart on this bit.
                        frame_err_set = 1'b1;
                        shreg_d       = {bus.sum_bit, {(WIDTH-1){1'b0}}};
                        cnt_d         = CW'(1);
                    end else if (cnt_q == LAST_IDX) begin
                        // WIDTH-th bit: the completed word is pushed on this edge.
                        push_req = 1'b1;
                        shreg_d  = '0;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers and sticky flags
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            if (frame_err_set) begin
                frame_err <= 1'b1;
            end
            if (push_req && fifo_full && !pop) begin
                overrun <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO control
    // -----------------------------------------------------------------------
    assign fifo_full = (count_q == 2'd2);
    assign pop       = bus.res_valid && bus.res_ready;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign do_push   = push_req && (!fifo_full || pop);

    // NOTE: the two storage entries are reset as well, which makes res_data
    // and res_cout read 0 straight out of reset without extra output gating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({do_push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.res_valid = (count_q != 2'd0);
    assign bus.res_data  = mem[rd_ptr][WIDTH-1:0];
    assign bus.res_cout  = mem[rd_ptr][WIDTH];
    assign busy          = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_sum_collector.sv
// ---------------------------------------------------------------------------
// tb_serial_sum_collector
//   Directed-vector bench for serial_sum_collector (WIDTH=8). Stimulus tasks
//   push the expected {cout, word} of every frame that should come out into
//   a scoreboard queue; a monitor on the falling edge pops and compares each
//   result the DUT hands over (res_valid && res_ready).
// ---------------------------------------------------------------------------
module tb_serial_sum_collector;

    localparam int WIDTH = 8;

    logic clk;
    logic reset;
    logic busy;
    logic overrun;
    logic frame_err;

    serial_sum_collector_if #(.WIDTH(WIDTH)) bus ();

    serial_sum_collector #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0] sb [$];   // expected {cout, word}

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: results are sampled mid-cycle, ahead of the edge that pops them.
    always @(negedge clk) begin
        if (!reset && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {23'd0, bus.res_cout, bus.res_data}, 32'hFFFF_FFFF);
            end else begin
                check("result", {23'd0, bus.res_cout, bus.res_data}, {23'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One accepted bit, then 'gap' idle cycles with sum_valid low.
    task automatic send_bit(input logic b, input logic fs, input logic co, input int gap);
        bus.sum_valid   = 1'b1;
        bus.sum_bit     = b;
        bus.frame_start = fs;
        bus.cout_bit    = co;
        next_cycle();
        bus.sum_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.cout_bit    = 1'b0;
        repeat (gap) next_cycle();
    endtask

    // Full frame; 'expect_out' queues the result, 'rdy_last' raises res_ready
    // exactly for the cycle in which the last bit is accepted.
    task automatic send_frame(input logic [WIDTH-1:0] word, input logic co, input int gap,
                              input logic expect_out, input logic rdy_last);
        if (expect_out) sb.push_back({co, word});
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH-1 && rdy_last) bus.res_ready = 1'b1;
            send_bit(word[i], i == 0, (i == WIDTH-1) ? co : 1'b0, gap);
        end
    endtask

    // Mid-cycle reset pulse; outputs must clear before any clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_res_data",  {24'd0, bus.res_data}, 32'd0);
        check("rst_res_cout",  {31'd0, bus.res_cout}, 32'd0);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_overrun",   {31'd0, overrun}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_sb_empty",  sb.size(), 32'd0);
        sb.delete();
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    initial begin
        reset           = 1'b1;
        bus.sum_bit     = 1'b0;
        bus.sum_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.cout_bit    = 1'b0;
        bus.res_ready   = 1'b0;
        repeat (2) next_cycle();
        do_reset();

        // Basic 0x5A frame, cout=1, consumer always ready.
        bus.res_ready = 1'b1;
        send_frame(8'h5A, 1'b1, 0, 1'b1, 1'b0);
        check("5a_valid", {31'd0, bus.res_valid}, 32'd1);
        check("5a_data",  {24'd0, bus.res_data}, 32'h5A);
        check("5a_cout",  {31'd0, bus.res_cout}, 32'd1);
        check("5a_busy",  {31'd0, busy}, 32'd0);
        next_cycle();
        check("5a_valid_one_cycle", {31'd0, bus.res_valid}, 32'd0);

        // Same frame with 3-cycle gaps; busy tracked after each bit.
        sb.push_back({1'b1, 8'h5A});
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(((8'h5A >> i) & 8'h01) != 0, i == 0, i == WIDTH-1, 3);
            check($sformatf("gap_busy_bit%0d", i + 1), {31'd0, busy}, (i < WIDTH-1) ? 32'd1 : 32'd0);
        end
        check("gap_frame_err", {31'd0, frame_err}, 32'd0);
        check("gap_overrun",   {31'd0, overrun}, 32'd0);
        next_cycle();
        check("gap_drained", {31'd0, bus.res_valid}, 32'd0);

        // Overrun: third word dropped while the consumer is stalled.
        do_reset();
        bus.res_ready = 1'b0;
        send_frame(8'h01, 1'b0, 0, 1'b1, 1'b0);
        send_frame(8'h02, 1'b0, 0, 1'b1, 1'b0);
        check("ovr_before", {31'd0, overrun}, 32'd0);
        send_frame(8'h03, 1'b0, 0, 1'b0, 1'b0);
        check("ovr_set",  {31'd0, overrun}, 32'd1);
        check("ovr_head", {24'd0, bus.res_data}, 32'h01);
        repeat (3) next_cycle();
        check("ovr_head_stable", {24'd0, bus.res_data}, 32'h01);
        check("ovr_valid_held",  {31'd0, bus.res_valid}, 32'd1);
        bus.res_ready = 1'b1;
        repeat (3) next_cycle();
        check("ovr_drained", {31'd0, bus.res_valid}, 32'd0);
        check("ovr_sticky",  {31'd0, overrun}, 32'd1);

        // Full FIFO, pop coincides with the completing push: no overrun.
        do_reset();
        bus.res_ready = 1'b0;
        send_frame(8'h11, 1'b0, 0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 0, 1'b1, 1'b0);
        send_frame(8'h33, 1'b0, 0, 1'b1, 1'b1);
        check("fullpop_overrun", {31'd0, overrun}, 32'd0);
        check("fullpop_head",    {24'd0, bus.res_data}, 32'h22);
        repeat (3) next_cycle();
        check("fullpop_drained", {31'd0, bus.res_valid}, 32'd0);

        // Truncated frame followed by a fresh 0xA5 frame.
        do_reset();
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0, 1'b0, 0);
        check("trunc_busy", {31'd0, busy}, 32'd1);
        send_frame(8'hA5, 1'b0, 0, 1'b1, 1'b0);
        check("trunc_frame_err", {31'd0, frame_err}, 32'd1);
        repeat (2) next_cycle();
        check("trunc_drained", {31'd0, bus.res_valid}, 32'd0);

        // Stray bit in IDLE.
        do_reset();
        send_bit(1'b1, 1'b0, 1'b0, 0);
        check("stray_frame_err", {31'd0, frame_err}, 32'd1);
        check("stray_busy",      {31'd0, busy}, 32'd0);
        check("stray_valid",     {31'd0, bus.res_valid}, 32'd0);

        // Reset mid-frame, then a clean 0xC3 frame.
        do_reset();
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0, 1'b0, 0);
        check("midrst_busy", {31'd0, busy}, 32'd1);
        do_reset();
        send_frame(8'hC3, 1'b0, 0, 1'b1, 1'b0);
        check("c3_data", {24'd0, bus.res_data}, 32'hC3);
        check("c3_cout", {31'd0, bus.res_cout}, 32'd0);
        repeat (2) next_cycle();
        check("c3_drained", {31'd0, bus.res_valid}, 32'd0);
        check("c3_no_err",  {31'd0, frame_err}, 32'd0);

        check("sb_final_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_sum_collector.md
SERIAL_SUM_COLLECTOR -- requirements
Module: serial_sum_collector

Interface
REQ-001 SHALL have parameter: WIDTH, 8, bits per result word (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: sum_bit  input  1  serial sum bit from the adder, LSB first.
REQ-005 SHALL have port: sum_valid  input  1  sum_bit (and frame_start, cout_bit) qualified this cycle.
REQ-006 SHALL have port: frame_start  input  1  marks sum_bit as bit 0 of a new word; meaningful only with sum_valid=1.
REQ-007 SHALL have port: cout_bit  input  1  adder carry-out, sampled only with the WIDTH-th bit of a frame.
REQ-008 SHALL have port: res_ready  input  1  downstream accepts the head result this cycle.
REQ-009 SHALL have port: res_data  output  WIDTH  head-of-buffer result word.
REQ-010 SHALL have port: res_cout  output  1  carry-out belonging to res_data.
REQ-011 SHALL have port: res_valid  output  1  buffer non-empty; res_data/res_cout valid.
REQ-012 SHALL have port: busy  output  1  frame in progress (state SHIFT).
REQ-013 SHALL have port: overrun  output  1  sticky; a completed word was dropped because the buffer was full.
REQ-014 SHALL have port: frame_err  output  1  sticky; stray bit or truncated frame detected.

Function
REQ-015 SHALL implement states IDLE and SHIFT, a bit counter 0..WIDTH-1, a WIDTH-bit shift register, and a 2-entry FIFO of {cout, word}.
REQ-016 IDLE, sum_valid=1, frame_start=1: capture sum_bit as bit 0, counter=1, go to SHIFT.
REQ-017 IDLE, sum_valid=1, frame_start=0: discard bit, set frame_err, stay IDLE.
REQ-018 sum_valid=0 in any state: no shift, no count, state held (gaps between bits allowed, unbounded).
REQ-019 SHIFT, sum_valid=1, frame_start=0: shift register shifts right with sum_bit inserted at MSB, counter increments.
REQ-020 On the WIDTH-th accepted bit: the word {sum_bit, shreg[WIDTH-1:1]} with cout_bit is pushed to the FIFO on that same edge, counter clears, state returns to IDLE.
REQ-021 SHIFT, sum_valid=1, frame_start=1: partial frame discarded, frame_err set, this bit taken as bit 0 of a new frame (counter=1, stay SHIFT).
REQ-022 Latency: res_valid SHALL rise on the edge that accepts the WIDTH-th bit (visible the following cycle) when the FIFO was empty.
REQ-023 Pop SHALL occur when res_valid=1 and res_ready=1; the next entry (if any) appears on the following cycle; FIFO order preserved.
REQ-024 Push with FIFO full and no pop in that cycle: word dropped, FIFO unchanged, overrun set.
REQ-025 Push with FIFO full and pop in the same cycle: pop and push both occur; no overrun.
REQ-026 res_data/res_cout SHALL be stable while res_valid=1 and res_ready=0.
REQ-027 busy SHALL be 1 exactly when state is SHIFT.
REQ-028 overrun and frame_err SHALL be cleared only by reset.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, counter=0, shift register=0, FIFO empty, all outputs 0 (res_data=0, res_cout=0, res_valid=0, busy=0, overrun=0, frame_err=0).
REQ-030 Reset asserted mid-frame SHALL discard the partial word with no push; the first frame_start after deassertion starts a clean frame.

Verification
REQ-031 WIDTH=8; frame of bits 0,1,0,1,1,0,1,0 (LSB first), cout_bit=1 on bit 8, res_ready=1 -> res_data=0x5A, res_cout=1, res_valid high for one cycle after the 8th-bit edge.
REQ-032 Same 0x5A frame with sum_valid=0 gaps of 3 cycles between bits -> identical result; busy high from bit 1 until the 8th-bit edge.
REQ-033 res_ready=0; send 0x01, 0x02, 0x03 -> FIFO holds 0x01, 0x02; overrun=1; then res_ready=1 -> outputs 0x01 then 0x02, then res_valid=0.
REQ-034 FIFO full (0x11, 0x22), res_ready=1 exactly on the cycle 0x33 completes -> no overrun; pops yield 0x11, 0x22, 0x33.
REQ-035 4 bits of a frame, then frame_start with a new 0xA5 frame -> frame_err=1, only 0xA5 output; stray sum_valid in IDLE also sets frame_err.
REQ-036 reset pulsed after bit 5 of a frame -> all outputs 0 immediately; next full frame 0xC3 outputs 0xC3 alone.
